// File: rtl/regfile_pkg.sv
// Shared datapath types and sizes for the integer register file.
// The mux, ALU and writeback stages reuse word_t from here.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [REG_AW-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: indexed read, x0 and out-of-range zeroing,
// and optional write-through forwarding of the data currently being written.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int DEPTH  = NREGS,
  parameter int ADDR_W = REG_AW,
  parameter int BYPASS = 1
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic                        rst,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           rd,
  input  logic [WIDTH-1:0]            wd,
  input  logic [ADDR_W-1:0]           rs,
  output logic [WIDTH-1:0]            rdata
);

  logic inRange;
  logic hitWrite;

  assign inRange  = (int'(rs) < DEPTH);
  assign hitWrite = (BYPASS != 0) && we && (rd == rs);

  // Reset and x0 force zero; forwarding is only considered for live, nonzero targets.
  always_comb begin
    rdata = '0;
    if (!rst && (rs != '0) && inRange) begin
      if (hitWrite) begin
        rdata = wd;
      end else begin
        rdata = regs[rs];
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit integer register file: storage and write logic here,
// two identical read ports instantiated from regfile_read_port.
module register_file
  import regfile_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int DEPTH  = NREGS,
  parameter int ADDR_W = REG_AW,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [WIDTH-1:0]  wd,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2
);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic                        writeOk;

  // The enable is checked first so an X address or data with we low cannot reach storage.
  assign writeOk = we && (rd != '0) && (int'(rd) < DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (writeOk) begin
      regs[rd] <= wd;
    end
  end

  regfile_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .BYPASS(BYPASS)
  ) readPort1 (
    .regs (regs),
    .rst  (rst),
    .we   (we),
    .rd   (rd),
    .wd   (wd),
    .rs   (rs1),
    .rdata(rd1)
  );

  regfile_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .BYPASS(BYPASS)
  ) readPort2 (
    .regs (regs),
    .rst  (rst),
    .we   (we),
    .rd   (rd),
    .wd   (wd),
    .rs   (rs2),
    .rdata(rd2)
  );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: one bypassing and one non-bypassing instance share
// the same inputs and are compared against an array model of the registers.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [31:0] rd1Byp;
  logic [31:0] rd2Byp;
  logic [31:0] rd1Nb;
  logic [31:0] rd2Nb;

  logic [31:0] model [32];
  int          checkCount;
  int          failCount;

  register_file #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .rs1(rs1), .rs2(rs2),
    .rd(rd), .wd(wd), .rd1(rd1Byp), .rd2(rd2Byp)
  );

  register_file #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .BYPASS(0)) dutNb (
    .clk(clk), .rst(rst), .we(we), .rs1(rs1), .rs2(rs2),
    .rd(rd), .wd(wd), .rd1(rd1Nb), .rd2(rd2Nb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Architectural read result: reset and x0 give zero, a forwarding port sees the pending write.
  function automatic logic [31:0] expectRead(input bit bypassOn, input logic [4:0] rsv);
    if (rst || rsv == 5'd0) return 32'h0;
    if (bypassOn && we && rd != 5'd0 && rd == rsv) return wd;
    return model[rsv];
  endfunction

  task automatic checkReads(input string tag);
    checkOutput({tag, "/byp.rd1"}, rd1Byp, expectRead(1'b1, rs1));
    checkOutput({tag, "/byp.rd2"}, rd2Byp, expectRead(1'b1, rs2));
    checkOutput({tag, "/nb.rd1"},  rd1Nb,  expectRead(1'b0, rs1));
    checkOutput({tag, "/nb.rd2"},  rd2Nb,  expectRead(1'b0, rs2));
  endtask

  task automatic applyStimulus(input logic weV, input logic [4:0] rdV, input logic [31:0] wdV,
                               input logic [4:0] rs1V, input logic [4:0] rs2V);
    @(negedge clk);
    we  = weV;
    rd  = rdV;
    wd  = wdV;
    rs1 = rs1V;
    rs2 = rs2V;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst && we && rd != 5'd0) model[rd] = wd;
    #1;
  endtask

  task automatic writeReg(input logic [4:0] rdV, input logic [31:0] wdV);
    applyStimulus(1'b1, rdV, wdV, rs1, rs2);
    tick();
    we = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1;
    we  = 1'b0;
    rd  = 5'd0;
    wd  = 32'h0;
    rs1 = 5'd5;
    rs2 = 5'd31;
    #1;
    checkReads("initReset");
    #2 rst = 1'b0;

    // Reset mid-cycle with no clock edge, holding a write request to x6 across it.
    writeReg(5'd5, 32'hDEADBEEF);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
    checkOutput("preReset.x5", rd1Byp, 32'hDEADBEEF);
    #1;
    rst = 1'b1;
    we  = 1'b1;
    rd  = 5'd6;
    wd  = 32'hCAFEF00D;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    checkOutput("inReset.x5", rd1Byp, 32'h0);
    checkReads("inReset");
    rst = 1'b0;
    #0.5;
    checkReads("released");
    tick();
    checkReads("firstEdge");
    checkOutput("firstEdge.x6", rd2Nb, 32'hCAFEF00D);
    we = 1'b0;

    // Basic write and dual-port read of the same register.
    writeReg(5'd7, 32'h12345678);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    checkReads("basic");
    checkOutput("basic.rd2", rd2Nb, 32'h12345678);

    // Writes to x0 are discarded and never forwarded.
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    checkReads("x0.bypass");
    tick();
    we = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    checkReads("x0.spot");
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd7);
    checkReads("x0.read");

    // Forwarding versus old value until the edge.
    writeReg(5'd3, 32'hAAAAAAAA);
    applyStimulus(1'b1, 5'd3, 32'h55555555, 5'd3, 5'd3);
    checkOutput("bypass.byp", rd1Byp, 32'h55555555);
    checkOutput("bypass.nbOld", rd1Nb, 32'hAAAAAAAA);
    checkReads("bypass");
    tick();
    checkOutput("bypass.nbNew", rd1Nb, 32'h55555555);
    we = 1'b0;

    // Write enable low, with defined and undefined address/data.
    writeReg(5'd9, 32'h00000001);
    applyStimulus(1'b0, 5'd9, 32'h87654321, 5'd1, 5'd9);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("weGate", rd2Byp, 32'h00000001);
    applyStimulus(1'b0, 5'bxxxxx, 32'hxxxxxxxx, 5'd9, 5'd3);
    for (int i = 0; i < 2; i++) tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd3);
    checkReads("xSafe");

    // Full sweep of every register, read back in mirrored pairs.
    for (int i = 1; i < 32; i++) writeReg(5'(i), 32'h10000000 + i);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
      checkOutput("sweep.rs1", rd1Nb, (i == 0) ? 32'h0 : 32'h10000000 + i);
      checkReads("sweep");
    end

    // Randomised traffic, biased toward address collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31)),
                    $urandom(),
                    ($urandom_range(0, 1) == 0) ? a : 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)));
      checkReads("rand");
      tick();
      checkReads("randPost");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit integer register file for the single-cycle datapath.
- Sits directly downstream of the writeback 2:1 mux, whose OUT drives WD here.
- Supplies the two source operands, RD1 and RD2, to the ALU-operand muxes.
- x0 is hardwired to zero; BYPASS selects write-through forwarding.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers.
- ADDR_W, 5, index width; must equal clog2(DEPTH).
- BYPASS, 1, when 1 a same-cycle read of the register being written returns WD.

Ports:
- CLK  input  1  system clock; all writes on rising edge.
- RST  input  1  reset, asynchronous, active-high; clears every register.
- WE  input  1  write enable (RegWrite from control).
- RS1  input  ADDR_W  read address, port 1.
- RS2  input  ADDR_W  read address, port 2.
- RD  input  ADDR_W  write address.
- WD  input  WIDTH  write data (writeback mux output).
- RD1  output  WIDTH  read data, port 1.
- RD2  output  WIDTH  read data, port 2.

Behaviour:
- Storage: array REGS[0..DEPTH-1] of WIDTH bits.
- Reset: RST high clears every REGS entry to 0 immediately, with no clock needed. While RST is high, RD1 = RD2 = 0 and writes are ignored.
- Reset release: takes effect on RST deassertion. The first write is accepted on the first rising CLK edge with RST low.
- Write: on rising CLK, if WE=1, RST=0 and RD!=0, then REGS[RD] <= WD. WE=0 leaves all entries unchanged.
- x0: writes to RD=0 are discarded. REGS[0] is always 0. A read of address 0 returns 0 regardless of WE, RD, WD or BYPASS.
- Read: combinational, zero latency.
  - RD1 = REGS[RS1]; RD2 = REGS[RS2].
  - Both ports are independent; RS1==RS2 is legal and both ports return identical data.
- Bypass (BYPASS=1): if WE=1, RD!=0 and RSx==RD, then RDx = WD in the same cycle, before the edge.
  - Both ports bypass simultaneously when RS1==RS2==RD.
- No bypass (BYPASS=0): a read of the register being written returns the old value until the edge, then the new value.
- Out-of-range addresses are not possible when DEPTH=2^ADDR_W. For other DEPTH values, reads of indices >= DEPTH return 0 and writes to them are discarded.
- Write latency: data is visible on a non-bypassed read immediately after the writing edge.
- X-safety: with WE=0, X on WD or RD must not corrupt any entry.

Decomposition:
- Shared package regfile_pkg holds:
  - localparams XLEN=32, NREGS=32, REG_AW=5.
  - constant REG_ZERO=5'd0.
  - typedef word_t = logic [XLEN-1:0].
  - typedef reg_idx_t = logic [REG_AW-1:0].
  - The mux, ALU and writeback stages reuse word_t from this package.
- The read path is duplicated per port. One sub-module is natural: regfile_read_port, which performs the indexed read, zero-detect and bypass compare, instantiated twice.
- The storage array and write logic stay in the top module.

Test Plan:
- Reset clears: write 0xDEADBEEF to x5, then pulse RST mid-cycle with no CLK edge. RD1 (RS1=5) goes to 0x00000000 immediately and stays 0 after release.
- Basic write/read: WE=1, RD=7, WD=0x12345678, one edge, then WE=0. RS1=7 and RS2=7 both read 0x12345678.
- x0 protection: WE=1, RD=0, WD=0xFFFFFFFF, one edge. RS1=0 reads 0x00000000. All other registers are unchanged; spot-check x1 and x31 read 0.
- Bypass, BYPASS=1: x3 holds 0xAAAAAAAA. Drive WE=1, RD=3, WD=0x55555555, RS1=3 before the edge: RD1=0x55555555. With BYPASS=0, RD1=0xAAAAAAAA before the edge and 0x55555555 after.
- WE gating: x9 holds 0x00000001. Drive WE=0, RD=9, WD=0x87654321 for three edges: RS2=9 still reads 0x00000001.
- Full sweep: write value 0x1000_0000+i to xi for i=1..31 on consecutive edges. Read back all pairs (RSx=i, 32-i): each returns its own value; x0 reads 0.
